// File: rtl/mm_line_reader_pkg.sv
// Shared types and helpers for the VGA memory-mapped line reader.
package vga_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ABORT
    } line_reader_state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mm_line_reader_if.sv
// Avalon-MM read port plus the ready/valid pixel stream of the line reader.
interface mm_line_reader_if
    import vga_mm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                                   mm_read;
    logic [ADDR_WIDTH-1:0]                  mm_address;
    logic [bytes_per_word(DATA_WIDTH)-1:0]  mm_byteenable;
    logic [DATA_WIDTH-1:0]                  mm_readdata;
    logic                                   mm_waitrequest;
    logic                                   mm_readdatavalid;
    logic                                   out_valid;
    logic [DATA_WIDTH-1:0]                  out_data;
    logic                                   out_ready;

    modport master (
        output mm_read, mm_address, mm_byteenable, out_valid, out_data,
        input  mm_readdata, mm_waitrequest, mm_readdatavalid, out_ready
    );

    modport slave (
        input  mm_read, mm_address, mm_byteenable, out_valid, out_data,
        output mm_readdata, mm_waitrequest, mm_readdatavalid, out_ready
    );
endinterface

// File: rtl/mm_line_reader_fifo.sv
// Synchronous FIFO with flush; count is exported so the reader can budget credits.
module fifo #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    output logic                          empty_o,
    output logic [$clog2(SIZE+1)-1:0]     count_o
);
    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [DATA_WIDTH-1:0] mem_q [SIZE];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  wr_en, rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en      = push_i && (count_q != CNT_W'(SIZE));
    assign rd_en      = pop_i && (count_q != '0);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (rd_en) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/mm_line_reader.sv
// Avalon-MM pipelined read master that fetches one video line into a FIFO
// and streams it out; issue is credit-limited by pending reads and FIFO room.
module mm_line_reader
    import vga_mm_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH    = 32,
    parameter int MEM_DATA_WIDTH    = 16,
    parameter int MAX_PENDING_READS = 4,
    parameter int FIFO_DEPTH        = 8,
    parameter int COUNT_WIDTH       = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic [MEM_ADDR_WIDTH-1:0] start_address_i,
    input  logic [COUNT_WIDTH-1:0]    word_count_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    mm_line_reader_if.master          bus
);
    localparam int PW  = $clog2(MAX_PENDING_READS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] BPW = MEM_ADDR_WIDTH'(bytes_per_word(MEM_DATA_WIDTH));

    line_reader_state_t        state_q, state_d;
    logic                      read_q, read_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [PW-1:0]             pending_q, pending_d;
    logic                      done_q, done_d;

    logic                      accept, rdv, push, pop, flush, can_issue, fifo_empty;
    logic [FCW-1:0]            fifo_count, fifo_count_next;

    assign accept = read_q && !bus.mm_waitrequest;
    // Returns with nothing outstanding are dropped so pending cannot underflow.
    assign rdv    = bus.mm_readdatavalid && (pending_q != '0);
    assign flush  = (state_q == ABORT) || (abort_i && (state_q == ISSUE || state_q == DRAIN));
    assign push   = rdv && !flush;
    assign pop    = bus.out_ready && !fifo_empty;

    assign pending_d       = pending_q + PW'(accept) - PW'(rdv);
    assign fifo_count_next = flush ? '0 : fifo_count + FCW'(push) - FCW'(pop);

    // Credits judged on post-edge occupancy, so a newly raised read always has a slot.
    always_comb begin
        can_issue = (int'(pending_d) < MAX_PENDING_READS) &&
                    (int'(pending_d) + int'(fifo_count_next) < FIFO_DEPTH);
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (accept) addr_d = addr_q + BPW;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (word_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        addr_d      = start_address_i;
                        remaining_d = word_count_i;
                        read_d      = can_issue;
                    end
                end
            end
            ISSUE: begin
                remaining_d = remaining_q - COUNT_WIDTH'(accept);
                if (abort_i) begin
                    state_d = ABORT;
                    read_d  = read_q && !accept;
                end else if (remaining_d == '0) begin
                    state_d = DRAIN;
                    read_d  = 1'b0;
                end else begin
                    read_d = (read_q && !accept) || can_issue;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = ABORT;
                end else if (pending_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ABORT: begin
                // A stalled read must still complete before the bus is released.
                read_d = read_q && !accept;
                if (pending_d == '0 && !read_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    fifo #(
        .SIZE       (FIFO_DEPTH),
        .DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (bus.mm_readdata),
        .pop_i       (pop),
        .pop_data_o  (bus.out_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign bus.mm_read       = read_q;
    assign bus.mm_address    = addr_q;
    assign bus.mm_byteenable = '1;
    assign bus.out_valid     = !fifo_empty;

    unsolicited_rdv_a: assert property (@(posedge clk) disable iff (!reset_n)
        bus.mm_readdatavalid |-> (pending_q != '0));
endmodule
